// File: rtl/dcache_tagarray_mp.sv
// Multi-read-port D-cache tag array: per-port sram copies, tag compare, invalidate sweep.
// Optional macro DCACHE_TAG_BYPASS_EN forwards a same-cycle write into matching reads.
`ifndef DCACHE_WAY_NUM
`define DCACHE_WAY_NUM 4
`endif

module dcache_tagarray_mp #(
  parameter int TAG_WIDTH  = 37,
  parameter int ADDR_WIDTH = 9,
  parameter int WAY_NUM    = `DCACHE_WAY_NUM,
  parameter int RD_PORTS   = 2
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  output logic                                     ready,
  input  logic [RD_PORTS-1:0]                      rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0]           rd_idx,
  input  logic [RD_PORTS*TAG_WIDTH-1:0]            rd_tag,
  output logic [RD_PORTS-1:0]                      rd_valid,
  output logic [RD_PORTS*WAY_NUM*(TAG_WIDTH+1)-1:0] rd_data,
  output logic [RD_PORTS*WAY_NUM-1:0]              rd_hit_way,
  output logic [RD_PORTS-1:0]                      rd_hit,
  input  logic                                     wr_en,
  input  logic [WAY_NUM-1:0]                       wr_way,
  input  logic [ADDR_WIDTH-1:0]                    wr_idx,
  input  logic [TAG_WIDTH-1:0]                     wr_tag,
  input  logic                                     wr_valid,
  input  logic                                     flush_req
);

  localparam int EW   = TAG_WIDTH + 1;
  localparam int NSET = 2 ** ADDR_WIDTH;
  localparam int PW   = WAY_NUM * EW;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_idx_q, sweep_idx_d;
  logic                    wr_fire;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [EW-1:0]           mem_wdata;
  logic [WAY_NUM-1:0]      mem_we;
  logic [RD_PORTS-1:0]     rd_valid_q, rd_valid_d;
  logic [RD_PORTS*TAG_WIDTH-1:0] rd_tag_q, rd_tag_d;
  logic [RD_PORTS*PW-1:0]  rd_data_q, rd_data_d;
  logic [RD_PORTS*PW-1:0]  sram_rd;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      S_INIT, S_FLUSH: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (&sweep_idx_q) begin
          state_d     = S_IDLE;
          sweep_idx_d = '0;
        end
      end
      S_IDLE: begin
        if (flush_req) begin
          state_d     = S_FLUSH;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = S_INIT;
        sweep_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign wr_fire = ready & wr_en & ~flush_req;

  // The sweep owns the write port; every way is cleared together.
  assign mem_waddr = ready ? wr_idx : sweep_idx_q;
  assign mem_wdata = ready ? {wr_valid, wr_tag} : '0;
  assign mem_we    = ready ? (wr_fire ? wr_way : '0) : '1;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
      logic [EW-1:0] mem [NSET];

      always_ff @(posedge clock) begin
        if (mem_we[w]) mem[mem_waddr] <= mem_wdata;
      end

      assign sram_rd[p*PW+w*EW +: EW] =
        mem[rd_idx[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  always_comb begin
    rd_valid_d = rd_en & {RD_PORTS{ready}};
    rd_tag_d   = rd_tag_q;
    rd_data_d  = rd_data_q;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rd_valid_d[p]) begin
        rd_tag_d[p*TAG_WIDTH +: TAG_WIDTH] = rd_tag[p*TAG_WIDTH +: TAG_WIDTH];
        for (int w = 0; w < WAY_NUM; w++) begin
          rd_data_d[p*PW+w*EW +: EW] = sram_rd[p*PW+w*EW +: EW];
`ifdef DCACHE_TAG_BYPASS_EN
          if (wr_fire && wr_way[w] &&
              wr_idx == rd_idx[p*ADDR_WIDTH +: ADDR_WIDTH])
            rd_data_d[p*PW+w*EW +: EW] = {wr_valid, wr_tag};
`endif
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= '0;
      rd_tag_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Compare against registered entry and tag so hits hold with the data.
  always_comb begin
    logic [EW-1:0] ent;
    ent        = '0;
    rd_hit_way = '0;
    rd_hit     = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        ent = rd_data_q[p*PW+w*EW +: EW];
        rd_hit_way[p*WAY_NUM+w] = ent[EW-1] &&
          (ent[TAG_WIDTH-1:0] == rd_tag_q[p*TAG_WIDTH +: TAG_WIDTH]);
      end
      rd_hit[p] = |rd_hit_way[p*WAY_NUM +: WAY_NUM];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/dcache_tagarray_mp.md
# dcache_tagarray_mp

Parametrised multi-read-port D-cache tag array with built-in tag compare and a hardware invalidate sweep. Each way is stored as one 1R1W sram instance per read port, and every write goes to all copies of that way. Reads return registered per-way `{valid, tag}` entries plus a one-hot hit vector. A sweep state machine clears every valid bit after reset and on a flush request. It sits between the load/store pipeline tag-read stages and the refill/writeback logic in the dcache.

## Interface
- `TAG_WIDTH`, 37: stored tag bits. An entry is `TAG_WIDTH+1` bits, with the valid bit as the MSB.
- `ADDR_WIDTH`, 9: set index width; the array has `2**ADDR_WIDTH` sets.
- `WAY_NUM`, `` `DCACHE_WAY_NUM ``: associativity.
- `RD_PORTS`, 2: number of independent read/compare ports.

Ports (the clock is `clock`; the reset is asynchronous and active-low and is named `reset_n`):
- `clock` in 1: the single clock.
- `reset_n` in 1: asynchronous active-low reset.
- `ready` out 1: high when the array is in IDLE and accepts reads and writes.
- `rd_en` in RD_PORTS: per-port read request.
- `rd_idx` in RD_PORTS*ADDR_WIDTH: per-port set index; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- `rd_tag` in RD_PORTS*TAG_WIDTH: per-port compare tag.
- `rd_valid` out RD_PORTS: the response for port p is valid this cycle.
- `rd_data` out RD_PORTS*WAY_NUM*(TAG_WIDTH+1): per-port, per-way entries; way w of port p sits at index (p*WAY_NUM+w).
- `rd_hit_way` out RD_PORTS*WAY_NUM: per-port hit vector.
- `rd_hit` out RD_PORTS: OR of that port's `rd_hit_way`.
- `wr_en` in 1: write request.
- `wr_way` in WAY_NUM: one-hot way select.
- `wr_idx` in ADDR_WIDTH: set index to write.
- `wr_tag` in TAG_WIDTH: tag to write.
- `wr_valid` in 1: valid bit to write.
- `flush_req` in 1: single-cycle pulse requesting an invalidate of all sets and ways.

## Operation
- The state machine has three states: INIT, IDLE and FLUSH. Reset enters INIT with the sweep counter `sweep_idx` = 0.
- INIT and FLUSH sweep the array:
  - Each cycle, all ways at `sweep_idx` are written with entry 0 and `sweep_idx` increments.
  - When `sweep_idx` = 2**ADDR_WIDTH-1 has been written, the next state is IDLE.
  - A sweep always takes exactly 2**ADDR_WIDTH cycles.
- `ready` = 1 only in IDLE. In INIT and FLUSH, `rd_en`, `wr_en` and `flush_req` are ignored and the external request is dropped, not queued.
- IDLE with `flush_req`=1 goes to FLUSH with `sweep_idx` = 0. A `wr_en` in the same cycle is dropped.
- Write in IDLE: for each way w with `wr_way[w]`=1, every copy of that way stores `{wr_valid, wr_tag}` at `wr_idx`. `wr_way`=0 writes nothing. A multi-hot `wr_way` writes all selected ways.
- Read in IDLE: port p with `rd_en[p]`=1 reads all ways at its index. The hit rule is `rd_hit_way[p*WAY_NUM+w]` = entry valid AND stored tag == the `rd_tag` slice registered in the request cycle.
- Ports are fully independent. Any mix of indices is allowed, including all ports on the same index.
- Multiple matching ways are not filtered; all matching bits are reported.
- The outputs `rd_data`, `rd_hit_way` and `rd_hit` hold their last value when the matching `rd_valid` is 0.
- If `reset_n` asserts mid-sweep or mid-read, the block returns to INIT with `sweep_idx` = 0 and all outputs are cleared.

## Timing
- Reset values: `ready`=0, and `rd_valid`, `rd_data`, `rd_hit_way` and `rd_hit` are all 0.
- Read latency is 1 cycle: a request in cycle T gives `rd_valid`, data and hit in T+1. Full throughput: one read per port per cycle.
- A write in cycle T is visible to reads issued in T+1 or later.
- A read and a write to the same index in the same cycle return the old contents unless `DCACHE_TAG_BYPASS_EN` is defined.
- `ready` rises in the cycle after the last sweep write, i.e. 2**ADDR_WIDTH cycles after reset release or after the FLUSH entry edge.

## Configuration
- The macro is `DCACHE_TAG_BYPASS_EN`.
- When it is defined, a same-cycle write whose `wr_idx` equals a read's `rd_idx` forwards `{wr_valid, wr_tag}` into that port's T+1 `rd_data` for the written ways. The hit is recomputed from the forwarded entry. Unwritten ways show sram data.
- When it is undefined, no forwarding occurs and the read returns the pre-write contents.

## Test plan
- Reset release with ADDR_WIDTH=4 -> `ready`=0 for 16 cycles, then 1. A read of every set and way then returns `rd_data`=0 and `rd_hit`=0.
- Write way 2, idx 0x05, tag 0x1234, valid 1. Next cycle, port 0 reads idx 5 with tag 0x1234 and port 1 reads idx 5 with tag 0x1235 -> port 0 gives `rd_hit_way`=0b0100 and `rd_hit`=1; port 1 gives `rd_hit`=0. Both have `rd_valid`=1 one cycle after the request.
- Same-cycle write of idx 7 way 0 tag 0xAA and read of idx 7 tag 0xAA -> without the macro, `rd_hit`=0; with the macro, `rd_hit`=1 and the way-0 entry = {1, 0xAA}.
- Populate sets 0, 3 and 15, then pulse `flush_req` while also asserting `wr_en` -> the write is dropped, `ready`=0 for 16 cycles, and all later reads miss.
- Assert `reset_n`=0 at sweep_idx=9 of a FLUSH, then release -> a full 16-cycle INIT runs before `ready`=1. `rd_en` asserted during INIT yields no `rd_valid`.
- Write the same tag to ways 0 and 3 of idx 2, then read it -> `rd_hit_way`=0b1001 and `rd_hit`=1.
